// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite word-addressed SRAM slave with wait states and ERROR response
// Drives one lane of the slave response mux; reads come straight from the array in the final data cycle.
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int REGION_AW   = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYOUT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = REGION_AW - 2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          write_q, write_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] idx_q, idx_d;

  logic [31:0]   mem [DEPTH];

  logic [IW-1:0] haddr_idx;
  logic          accept, size_err, range_err, final_cyc, mem_we;
  logic [3:0]    be_addr;
  logic          unused_bits;

  assign haddr_idx   = HADDR[REGION_AW-1:2];
  assign unused_bits = ^{HADDR[31:REGION_AW], HTRANS[0]};
  assign range_err   = (32'(haddr_idx) >= 32'(DEPTH));
  assign accept      = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  always_comb begin
    size_err = 1'b0;
    be_addr  = 4'b1111;
    case (HSIZE)
      3'b000: be_addr = 4'b0001 << HADDR[1:0];
      3'b001: begin
        size_err = HADDR[0];
        be_addr  = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: size_err = |HADDR[1:0];
      default: size_err = 1'b1;
    endcase
  end

  // The final cycle of a legal transfer is the only one that touches the array or HRDATA.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    final_cyc = 1'b0;
    case (state_q)
      S_IDLE: final_cyc = active_q;
      S_WAIT: begin
        HREADYOUT = (cnt_q == WAIT_LAST);
        final_cyc = (cnt_q == WAIT_LAST);
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
      end
      S_ERR2: HRESP = 2'b01;
      default: ;
    endcase
  end

  assign mem_we = final_cyc & write_q & HREADY;
  assign HRDATA = (final_cyc && !write_q) ? mem[idx_q] : 32'h0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    write_d  = write_q;
    be_d     = be_q;
    idx_d    = idx_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (state_q == S_WAIT && !HREADYOUT) begin
      cnt_d = cnt_q + 4'd1;
    end else if (HREADY) begin
      state_d  = S_IDLE;
      active_d = 1'b0;
      cnt_d    = 4'd0;
      if (accept) begin
        if (size_err || range_err) begin
          state_d = S_ERR1;
        end else begin
          active_d = 1'b1;
          write_d  = HWRITE;
          be_d     = be_addr;
          idx_d    = haddr_idx[AW-1:0];
          state_d  = (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
      write_q  <= 1'b0;
      be_q     <= 4'd0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      write_q  <= write_d;
      be_q     <= be_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed bench for ahb_sram_slave
// Instance 0 runs with zero wait states, instance 1 with three.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel    [2];
  logic [31:0] haddr   [2];
  logic [1:0]  htrans  [2];
  logic        hwrite  [2];
  logic [2:0]  hsize   [2];
  logic [31:0] hwdata  [2];
  logic        hready  [2];
  logic        stall   [2];
  logic [31:0] hrdata  [2];
  logic [1:0]  hresp   [2];
  logic        hreadyout [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign hready[0] = stall[0] ? 1'b0 : hreadyout[0];
  assign hready[1] = stall[1] ? 1'b0 : hreadyout[1];

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0), .REGION_AW(16)) u_dut0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADYOUT(hreadyout[0])
  );

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3), .REGION_AW(16)) u_dut1 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADYOUT(hreadyout[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int d, input bit sel, input logic [1:0] tr, input bit wr,
                          input logic [2:0] sz, input logic [31:0] a);
    hsel[d]   = sel;
    htrans[d] = tr;
    hwrite[d] = wr;
    hsize[d]  = sz;
    haddr[d]  = a;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] resp,
                      output int waits);
    set_addr(d, 1'b1, 2'b10, wr, sz, a);
    tick();
    set_addr(d, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    hwdata[d] = wd;
    waits = 0;
    while (!hreadyout[d] && waits < 40) begin
      waits++;
      tick();
    end
    rd   = hrdata[d];
    resp = hresp[d];
    tick();
  endtask

  logic [31:0] rd;
  logic [1:0]  resp;
  int          waits;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      set_addr(d, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
      hwdata[d] = 32'h0;
      stall[d]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
      check_eq("rst_hresp", 32'(hresp[d]), 32'd0);
      check_eq("rst_hrdata", hrdata[d], 32'h0);
    end
    hresetn = 1'b1;
    tick();

    // Zero-wait pipelined write then read of the same word.
    set_addr(0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h10);
    tick();
    set_addr(0, 1'b1, 2'b10, 1'b0, 3'b010, 32'h10);
    hwdata[0] = 32'hCAFEF00D;
    check_eq("b2b_wr_ready", 32'(hreadyout[0]), 32'd1);
    check_eq("b2b_wr_resp", 32'(hresp[0]), 32'd0);
    tick();
    set_addr(0, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    check_eq("b2b_rd_data", hrdata[0], 32'hCAFEF00D);
    check_eq("b2b_rd_ready", 32'(hreadyout[0]), 32'd1);
    check_eq("b2b_rd_resp", 32'(hresp[0]), 32'd0);
    tick();
    check_eq("idle_rdata_zero", hrdata[0], 32'h0);

    // Byte and halfword lane writes.
    xfer(0, 1'b1, 3'b010, 32'h10, 32'h11223344, rd, resp, waits);
    xfer(0, 1'b1, 3'b000, 32'h13, 32'hAB998877, rd, resp, waits);
    xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, resp, waits);
    check_eq("byte_wr", rd, 32'hAB223344);
    xfer(0, 1'b1, 3'b001, 32'h12, 32'h55661234, rd, resp, waits);
    xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, resp, waits);
    check_eq("half_wr", rd, 32'h55663344);
    check_eq("half_wr_waits", 32'(waits), 32'd0);

    // Illegal accesses: each two-cycle ERROR, array untouched.
    xfer(0, 1'b1, 3'b010, 32'h0, 32'h01234567, rd, resp, waits);
    xfer(0, 1'b1, 3'b010, 32'h02, 32'hFFFFFFFF, rd, resp, waits);
    check_eq("err_misalign_resp", 32'(resp), 32'd1);
    check_eq("err_misalign_waits", 32'(waits), 32'd1);
    xfer(0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, rd, resp, waits);
    check_eq("err_size_resp", 32'(resp), 32'd1);
    check_eq("err_size_waits", 32'(waits), 32'd1);
    xfer(0, 1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, rd, resp, waits);
    check_eq("err_range_resp", 32'(resp), 32'd1);
    check_eq("err_range_waits", 32'(waits), 32'd1);
    xfer(0, 1'b0, 3'b010, 32'h0, 32'h0, rd, resp, waits);
    check_eq("err_word0_kept", rd, 32'h01234567);
    check_eq("err_after_resp", 32'(resp), 32'd0);
    xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, resp, waits);
    check_eq("err_word4_kept", rd, 32'h55663344);

    // HSEL with IDLE, and a NONSEQ while another slave stalls.
    set_addr(0, 1'b1, 2'b00, 1'b1, 3'b010, 32'h10);
    tick();
    set_addr(0, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    hwdata[0] = 32'hDEADBEEF;
    check_eq("idle_ready", 32'(hreadyout[0]), 32'd1);
    check_eq("idle_resp", 32'(hresp[0]), 32'd0);
    tick();
    stall[0] = 1'b1;
    set_addr(0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h10);
    tick();
    stall[0] = 1'b0;
    set_addr(0, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    check_eq("stall_ready", 32'(hreadyout[0]), 32'd1);
    check_eq("stall_resp", 32'(hresp[0]), 32'd0);
    tick();
    xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, resp, waits);
    check_eq("noacc_word4_kept", rd, 32'h55663344);

    // Three wait states, with a second NONSEQ held on the bus during the wait.
    xfer(1, 1'b1, 3'b010, 32'h20, 32'h600DBEEF, rd, resp, waits);
    check_eq("ws3_wr_waits", 32'(waits), 32'd3);
    xfer(1, 1'b1, 3'b010, 32'h24, 32'h24242424, rd, resp, waits);
    set_addr(1, 1'b1, 2'b10, 1'b0, 3'b010, 32'h20);
    tick();
    set_addr(1, 1'b1, 2'b10, 1'b0, 3'b010, 32'h24);
    for (int i = 0; i < 3; i++) begin
      check_eq("ws3_rd1_low", 32'(hreadyout[1]), 32'd0);
      check_eq("ws3_rd1_resp", 32'(hresp[1]), 32'd0);
      check_eq("ws3_rd1_zero", hrdata[1], 32'h0);
      tick();
    end
    check_eq("ws3_rd1_high", 32'(hreadyout[1]), 32'd1);
    check_eq("ws3_rd1_data", hrdata[1], 32'h600DBEEF);
    tick();
    set_addr(1, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("ws3_rd2_low", 32'(hreadyout[1]), 32'd0);
      tick();
    end
    check_eq("ws3_rd2_high", 32'(hreadyout[1]), 32'd1);
    check_eq("ws3_rd2_data", hrdata[1], 32'h24242424);
    tick();
    check_eq("ws3_after_ready", 32'(hreadyout[1]), 32'd1);

    // Reset during the second wait cycle of a write drops the write.
    set_addr(1, 1'b1, 2'b10, 1'b1, 3'b010, 32'h20);
    tick();
    set_addr(1, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    hwdata[1] = 32'hDEADDEAD;
    tick();
    check_eq("rstmid_pre_low", 32'(hreadyout[1]), 32'd0);
    hresetn = 1'b0;
    #1;
    check_eq("rstmid_ready", 32'(hreadyout[1]), 32'd1);
    check_eq("rstmid_resp", 32'(hresp[1]), 32'd0);
    check_eq("rstmid_rdata", hrdata[1], 32'h0);
    @(posedge clk);
    #1;
    hresetn = 1'b1;
    tick();
    xfer(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, resp, waits);
    check_eq("rstmid_old_data", rd, 32'h600DBEEF);
    check_eq("rstmid_rd_waits", 32'(waits), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
